// File: rtl/irrigation_matrix_scanner.sv
// -----------------------------------------------------------------------------
// irrigation_matrix_scanner
//   Column-scanned 5x7 LED matrix driver that shows the irrigation-mode glyph
//   (off / sprinkler / dripper / fault). One column is driven per slot of
//   SCAN_DIV cycles. The rows are blanked for the first BLANK_CYCLES of each
//   slot so the previous column's data does not ghost into the new column.
//   The mode and the blink enable are latched only at frame boundaries, so
//   no frame ever mixes two glyphs. The fault glyph always blinks.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   mode[1:0]    00 off, 01 sprinkler, 10 dripper, 11 fault
//   blink_en     blink the sprinkler/dripper glyph
//   col_sel[4:0] one-hot column select (polarity from COL_ACTIVE_LOW)
//   rows[6:0]    row data, bit 6 = top row (polarity from ROW_ACTIVE_LOW)
//   frame_start  one-cycle pulse while column 0 / prescaler 0 is on the pins
// -----------------------------------------------------------------------------
module irrigation_matrix_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYCLES   = 1,
    parameter int BLINK_FRAMES   = 50,
    parameter int COL_ACTIVE_LOW = 1,
    parameter int ROW_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       blink_en,
    output logic [4:0] col_sel,
    output logic [6:0] rows,
    output logic       frame_start
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [4:0] COL_INV = (COL_ACTIVE_LOW != 0) ? 5'h1F : 5'h00;
    localparam logic [6:0] ROW_INV = (ROW_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_col;
    logic [BF_W-1:0]  r_bf;
    logic             r_blink_phase;
    logic [1:0]       r_mode_q;
    logic             r_blink_q;

    logic [4:0]       r_col_sel;
    logic [6:0]       r_rows;
    logic             r_frame_start;

    logic             w_pre_wrap;
    logic             w_frame_end;
    logic             w_dark;
    logic [6:0]       w_rows_ah;
    logic [4:0]       w_col_oh;

    // Glyphs are mirror-symmetric, so only outer/inner/centre columns differ.
    function automatic logic [6:0] glyph(input logic [1:0] m, input logic [2:0] c);
        logic [1:0] pos;   // 0 outer, 1 inner, 2 centre
        logic [6:0] g;
        pos = (c == 3'd2) ? 2'd2 : ((c == 3'd1 || c == 3'd3) ? 2'd1 : 2'd0);
        g   = 7'h00;
        case (m)
            2'b01:   g = (pos == 2'd2) ? 7'h7F : ((pos == 2'd1) ? 7'h1F : 7'h59);
            2'b10:   g = (pos == 2'd2) ? 7'h7F : ((pos == 2'd1) ? 7'h23 : 7'h0E);
            2'b11:   g = (pos == 2'd2) ? 7'h1C : ((pos == 2'd1) ? 7'h22 : 7'h41);
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    always_comb begin
        w_pre_wrap  = (r_pre == PRE_W'(SCAN_DIV - 1));
        w_frame_end = w_pre_wrap && (r_col == 3'd4);
        w_dark      = (r_pre < PRE_W'(BLANK_CYCLES))
                   || (r_mode_q == 2'b00)
                   || (r_blink_phase && (r_blink_q || r_mode_q == 2'b11));
        w_rows_ah   = w_dark ? 7'h00 : glyph(r_mode_q, r_col);
        w_col_oh    = 5'b00001 << r_col;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre         <= '0;
            r_col         <= '0;
            r_bf          <= '0;
            r_blink_phase <= 1'b0;
            r_mode_q      <= 2'b00;
            r_blink_q     <= 1'b0;
            r_col_sel     <= 5'h00;
            r_rows        <= 7'h00;
            r_frame_start <= 1'b0;
        end else begin
            if (w_pre_wrap) begin
                r_pre <= '0;
                r_col <= (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end

            if (w_frame_end) begin
                r_mode_q  <= mode;
                r_blink_q <= blink_en;
                if (r_bf == BF_W'(BLINK_FRAMES - 1)) begin
                    r_bf          <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_bf <= r_bf + BF_W'(1);
                end
            end

            // Outputs show the state of the previous cycle (fixed 1-cycle lag).
            r_col_sel     <= w_col_oh;
            r_rows        <= w_rows_ah;
            r_frame_start <= (r_col == 3'd0) && (r_pre == '0);
        end
    end

    // Polarity inversion sits after everything, reset values included.
    assign col_sel     = r_col_sel ^ COL_INV;
    assign rows        = r_rows ^ ROW_INV;
    assign frame_start = r_frame_start;

endmodule
